// File: rtl/seq_mult8_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult8_if
//  Description : Handshake and operand/result bundle for the sequential
//                shift-and-add multiplier (start/busy/done, a, b, product).
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_mult8_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  // Requester side: issues operands and start, observes status and result
  modport master (
    output start, a, b,
    input  busy, done, product
  );

  // Multiplier side
  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface
`default_nettype wire

// File: rtl/seq_mult8.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult8
//  Description : Unsigned shift-and-add multiplier. One WIDTH-bit add with
//                carry per clock, WIDTH iterations, 2*WIDTH-bit product held
//                until the next completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mult8 #(
  parameter int WIDTH = 8
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  seq_mult8_if.slave      bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q,   state_d;
  logic [WIDTH-1:0]   mcand_q,   mcand_d;
  logic [WIDTH-1:0]   acc_hi_q,  acc_hi_d;
  logic [WIDTH-1:0]   mult_q,    mult_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  // Partial-product add: carry-out kept as the top bit so it shifts into acc_hi
  logic [WIDTH:0] add_res;
  assign add_res = mult_q[0] ? ({1'b0, acc_hi_q} + {1'b0, mcand_q})
                             : {1'b0, acc_hi_q};

  // State register and datapath flops, cleared immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      mult_q    <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      mult_q    <= mult_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Next-state and datapath update: load on accepted start, shift/add in RUN
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    mult_d    = mult_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          mcand_d  = bus.a;
          mult_d   = bus.b;
          acc_hi_d = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end else begin
          // DONE lasts exactly one cycle
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // (2*WIDTH+1)-bit right shift of {carry, sum, mult}; LSB of mult drops out
        {acc_hi_d, mult_d} = {add_res, mult_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST) begin
          product_d = {add_res, mult_q[WIDTH-1:1]};
          state_d   = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Status decoded straight from the state flop, so outputs stay registered
  assign bus.busy    = (state_q == ST_RUN);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.product = product_q;

endmodule
`default_nettype wire
